// File: rtl/rv_mem_pkg.sv
// Shared types and arbitration helpers for the rv_mem_arb memory arbiter.
package rv_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic {CH_IF, CH_LS} chan_t;

    localparam int PRIO_IF = 0;
    localparam int PRIO_LS = 1;
    localparam int PRIO_RR = 2;

    // Only a simultaneous request consults the policy; round-robin favours the channel not served last.
    function automatic chan_t pick_chan(input int prio, input logic if_req, input logic ls_req,
                                        input chan_t last_served);
        if (if_req && !ls_req) return CH_IF;
        if (ls_req && !if_req) return CH_LS;
        case (prio)
            PRIO_IF: return CH_IF;
            PRIO_LS: return CH_LS;
            default: return (last_served == CH_IF) ? CH_LS : CH_IF;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_arb_if.sv
// Core-side channels, shared memory bus and status/debug signals of rv_mem_arb.
interface rv_mem_arb_if #(
    parameter int DPWIDTH = 32
);
    import rv_mem_pkg::*;

    localparam int BEWIDTH = DPWIDTH / 8;

    // Handshake: if_req/ls_req are levels held until the matching one-cycle done pulse.
    // bus_req is held with stable fields until bus_gnt is seen at an edge; the first
    // bus_rvalid after that grant carries read data or acknowledges a write.
    logic               if_req;
    logic [DPWIDTH-1:0] if_addr;
    logic [DPWIDTH-1:0] if_rdata;
    logic               if_done;
    logic               ls_req;
    logic               ls_we;
    logic [BEWIDTH-1:0] ls_be;
    logic [DPWIDTH-1:0] ls_addr;
    logic [DPWIDTH-1:0] ls_wdata;
    logic [DPWIDTH-1:0] ls_rdata;
    logic               ls_done;
    logic               stall;
    logic               bus_req;
    logic               bus_we;
    logic [BEWIDTH-1:0] bus_be;
    logic [DPWIDTH-1:0] bus_addr;
    logic [DPWIDTH-1:0] bus_wdata;
    logic               bus_gnt;
    logic               bus_rvalid;
    logic [DPWIDTH-1:0] bus_rdata;
    logic               err;
    logic               err_clr;
    state_t             dbg_state;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
               bus_gnt, bus_rvalid, bus_rdata, err_clr,
        output if_rdata, if_done, ls_rdata, ls_done, stall,
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, err, dbg_state
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
               bus_gnt, bus_rvalid, bus_rdata, err_clr,
        input  if_rdata, if_done, ls_rdata, ls_done, stall,
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, err, dbg_state
    );

endinterface

// File: rtl/rv_mem_timeout.sv
// Bus-access watchdog: counts busy cycles and flags the TIMEOUT-th one.
module rv_mem_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TOWIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TOWIDTH-1:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == TOWIDTH'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TOWIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv_mem_arb.sv
// Stall-capable arbiter merging fetch and load/store channels onto one req/gnt/rvalid bus.
module rv_mem_arb
    import rv_mem_pkg::*;
#(
    parameter int DPWIDTH  = 32,
    parameter int BEWIDTH  = DPWIDTH / 8,
    parameter int TIMEOUT  = 255,
    parameter int TOWIDTH  = $clog2(TIMEOUT + 1),
    parameter int PRIORITY = 1
) (
    input logic         clk,
    input logic         rst,
    rv_mem_arb_if.slave io
);

    localparam logic [DPWIDTH-1:0] ADDR_MASK = ~(DPWIDTH'(BEWIDTH - 1));

    state_t             state_q, state_d;
    chan_t              chan_q, chan_d, rr_last_q, rr_last_d, sel;
    logic               bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [BEWIDTH-1:0] bus_be_q, bus_be_d;
    logic [DPWIDTH-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [DPWIDTH-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic               if_done_q, if_done_d, ls_done_q, ls_done_d;
    logic               err_q, err_d;
    logic               finish, to_set, tmo_expired;
    logic [DPWIDTH-1:0] fin_data;

    rv_mem_timeout #(.TIMEOUT(TIMEOUT), .TOWIDTH(TOWIDTH)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state_q == IDLE) || (state_q == DONE)),
        .en     ((state_q == REQ) || (state_q == WAIT)),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        rr_last_d   = rr_last_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        finish      = 1'b0;
        fin_data    = '0;
        to_set      = 1'b0;
        sel         = pick_chan(PRIORITY, io.if_req, io.ls_req, rr_last_q);

        case (state_q)
            IDLE: begin
                if (io.if_req || io.ls_req) begin
                    state_d   = REQ;
                    chan_d    = sel;
                    rr_last_d = sel;
                    bus_req_d = 1'b1;
                    if (sel == CH_IF) begin
                        bus_we_d    = 1'b0;
                        bus_be_d    = '1;
                        bus_addr_d  = io.if_addr & ADDR_MASK;
                        bus_wdata_d = '0;
                    end else begin
                        bus_we_d    = io.ls_we;
                        bus_be_d    = io.ls_be;
                        bus_addr_d  = io.ls_addr & ADDR_MASK;
                        bus_wdata_d = io.ls_wdata;
                    end
                end
            end
            // An expiring request is abandoned even if granted that same cycle.
            REQ: begin
                if (tmo_expired) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    finish    = 1'b1;
                    to_set    = 1'b1;
                end else if (io.bus_gnt) begin
                    state_d   = WAIT;
                    bus_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (io.bus_rvalid) begin
                    state_d  = DONE;
                    finish   = 1'b1;
                    fin_data = io.bus_rdata;
                end else if (tmo_expired) begin
                    state_d = DONE;
                    finish  = 1'b1;
                    to_set  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Done and read data become visible together on entry to DONE.
        if (finish) begin
            if (chan_q == CH_IF) begin
                if_done_d = 1'b1;
                if (!bus_we_q) if_rdata_d = fin_data;
            end else begin
                ls_done_d = 1'b1;
                if (!bus_we_q) ls_rdata_d = fin_data;
            end
        end

        err_d = to_set ? 1'b1 : (io.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            chan_q      <= CH_IF;
            rr_last_q   <= CH_IF;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            rr_last_q   <= rr_last_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            err_q       <= err_d;
        end
    end

    assign io.bus_req   = bus_req_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_be    = bus_be_q;
    assign io.bus_addr  = bus_addr_q;
    assign io.bus_wdata = bus_wdata_q;
    assign io.if_rdata  = if_rdata_q;
    assign io.ls_rdata  = ls_rdata_q;
    assign io.if_done   = if_done_q;
    assign io.ls_done   = ls_done_q;
    assign io.err       = err_q;
    assign io.dbg_state = state_q;
    assign io.stall     = (io.if_req & ~if_done_q) | (io.ls_req & ~ls_done_q);

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: dut_a runs data-priority, dut_b round-robin, both TIMEOUT=8.
module tb_rv_mem_arb;
    import rv_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_ls_rdata = '0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    rv_mem_arb_if #(.DPWIDTH(32)) ia ();
    rv_mem_arb_if #(.DPWIDTH(32)) ib ();

    rv_mem_arb #(.DPWIDTH(32), .TIMEOUT(8), .PRIORITY(PRIO_LS)) dut_a (.clk(clk), .rst(rst), .io(ia));
    rv_mem_arb #(.DPWIDTH(32), .TIMEOUT(8), .PRIORITY(PRIO_RR)) dut_b (.clk(clk), .rst(rst), .io(ib));

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia.if_req = 0; ia.if_addr = '0; ia.ls_req = 0; ia.ls_we = 0; ia.ls_be = '0;
        ia.ls_addr = '0; ia.ls_wdata = '0; ia.bus_gnt = 0; ia.bus_rvalid = 0; ia.bus_rdata = '0;
        ia.err_clr = 0;
        ib.if_req = 0; ib.if_addr = '0; ib.ls_req = 0; ib.ls_we = 0; ib.ls_be = '0;
        ib.ls_addr = '0; ib.ls_wdata = '0; ib.bus_gnt = 0; ib.bus_rvalid = 0; ib.bus_rdata = '0;
        ib.err_clr = 0;
    endtask

    // Called in the first REQ cycle; returns in the DONE cycle.
    task automatic a_serve(input logic [31:0] d);
        ia.bus_gnt = 1; tick();
        ia.bus_gnt = 0; ia.bus_rvalid = 1; ia.bus_rdata = d; tick();
        ia.bus_rvalid = 0;
    endtask

    task automatic b_serve(input logic [31:0] d);
        ib.bus_gnt = 1; tick();
        ib.bus_gnt = 0; ib.bus_rvalid = 1; ib.bus_rdata = d; tick();
        ib.bus_rvalid = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 0;
        repeat (3) tick();
        total++; if (ia.dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", ia.dbg_state, IDLE); end
        total++; if ({ia.bus_req, ia.bus_we, ia.bus_be, ia.if_done, ia.ls_done, ia.err} !== 9'h0) begin
            bad++; $display("FAIL rst_ctrl got=%h exp=0", {ia.bus_req, ia.bus_we, ia.bus_be, ia.if_done, ia.ls_done, ia.err}); end
        total++; if ({ia.bus_addr, ia.bus_wdata, ia.if_rdata, ia.ls_rdata} !== 128'h0) begin
            bad++; $display("FAIL rst_data got=%h exp=0", {ia.bus_addr, ia.bus_wdata, ia.if_rdata, ia.ls_rdata}); end
        total++; if (ib.dbg_state !== IDLE || ib.bus_req !== 1'b0) begin bad++; $display("FAIL rst_b got=%0d/%b exp=0/0", ib.dbg_state, ib.bus_req); end
        rst = 1;
        tick();
    endtask

    task automatic test_single_fetch();
        ia.if_req = 1; ia.if_addr = 32'h0000_1006;
        tick();
        total++; if (ia.bus_req !== 1'b1) begin bad++; $display("FAIL fetch_req got=%b exp=1", ia.bus_req); end
        total++; if (ia.bus_addr !== 32'h0000_1004) begin bad++; $display("FAIL fetch_addr got=%h exp=00001004", ia.bus_addr); end
        total++; if (ia.bus_be !== 4'hF || ia.bus_we !== 1'b0) begin bad++; $display("FAIL fetch_be_we got=%h/%b exp=f/0", ia.bus_be, ia.bus_we); end
        total++; if (ia.stall !== 1'b1) begin bad++; $display("FAIL fetch_stall1 got=%b exp=1", ia.stall); end
        ia.bus_gnt = 1;
        tick();
        ia.bus_gnt = 0; ia.bus_rvalid = 1; ia.bus_rdata = 32'h0041_0113;
        total++; if (ia.bus_req !== 1'b0 || ia.dbg_state !== WAIT) begin bad++; $display("FAIL fetch_wait got=%b/%0d exp=0/%0d", ia.bus_req, ia.dbg_state, WAIT); end
        total++; if (ia.if_done !== 1'b0) begin bad++; $display("FAIL fetch_early_done got=%b exp=0", ia.if_done); end
        tick();
        ia.bus_rvalid = 0;
        exp_if_rdata = 32'h0041_0113;
        total++; if (ia.if_done !== 1'b1) begin bad++; $display("FAIL fetch_done got=%b exp=1", ia.if_done); end
        total++; if (ia.if_rdata !== exp_if_rdata) begin bad++; $display("FAIL fetch_rdata got=%h exp=%h", ia.if_rdata, exp_if_rdata); end
        total++; if (ia.stall !== 1'b0) begin bad++; $display("FAIL fetch_stall_done got=%b exp=0", ia.stall); end
        ia.if_req = 0;
        tick();
        total++; if (ia.if_done !== 1'b0 || ia.stall !== 1'b0) begin bad++; $display("FAIL fetch_after got=%b/%b exp=0/0", ia.if_done, ia.stall); end
        total++; if (ia.if_rdata !== exp_if_rdata) begin bad++; $display("FAIL fetch_hold got=%h exp=%h", ia.if_rdata, exp_if_rdata); end
    endtask

    task automatic test_priority();
        ia.if_req = 1; ia.if_addr = 32'h0000_0300;
        ia.ls_req = 1; ia.ls_we = 0; ia.ls_be = 4'hF; ia.ls_addr = 32'h0000_0404; ia.ls_wdata = '0;
        tick();
        total++; if (ia.bus_addr !== 32'h0000_0404) begin bad++; $display("FAIL prio_first got=%h exp=00000404", ia.bus_addr); end
        a_serve(32'hAAAA_0001);
        exp_ls_rdata = 32'hAAAA_0001;
        total++; if (ia.ls_done !== 1'b1 || ia.if_done !== 1'b0) begin bad++; $display("FAIL prio_ls_done got=%b/%b exp=1/0", ia.ls_done, ia.if_done); end
        total++; if (ia.ls_rdata !== exp_ls_rdata) begin bad++; $display("FAIL prio_ls_rdata got=%h exp=%h", ia.ls_rdata, exp_ls_rdata); end
        total++; if (ia.stall !== 1'b1) begin bad++; $display("FAIL prio_stall got=%b exp=1", ia.stall); end
        ia.ls_req = 0;
        tick();
        total++; if (ia.dbg_state !== IDLE || ia.ls_done !== 1'b0) begin bad++; $display("FAIL prio_idle got=%0d/%b exp=%0d/0", ia.dbg_state, ia.ls_done, IDLE); end
        tick();
        total++; if (ia.bus_req !== 1'b1 || ia.bus_addr !== 32'h0000_0300) begin bad++; $display("FAIL prio_second got=%b/%h exp=1/00000300", ia.bus_req, ia.bus_addr); end
        a_serve(32'hBBBB_0002);
        exp_if_rdata = 32'hBBBB_0002;
        total++; if (ia.if_done !== 1'b1 || ia.if_rdata !== exp_if_rdata) begin bad++; $display("FAIL prio_if got=%b/%h exp=1/%h", ia.if_done, ia.if_rdata, exp_if_rdata); end
        total++; if (ia.ls_rdata !== exp_ls_rdata) begin bad++; $display("FAIL prio_ls_keep got=%h exp=%h", ia.ls_rdata, exp_ls_rdata); end
        ia.if_req = 0;
        tick();
    endtask

    task automatic test_store_stall();
        ia.ls_req = 1; ia.ls_we = 1; ia.ls_be = 4'b0011; ia.ls_addr = 32'h0000_0200; ia.ls_wdata = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 5; k++) begin
            total++; if ({ia.bus_req, ia.bus_we, ia.bus_be, ia.bus_addr, ia.bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF}) begin
                bad++; $display("FAIL store_hold%0d got=%b/%b/%h/%h/%h exp=1/1/3/00000200/deadbeef", k, ia.bus_req, ia.bus_we, ia.bus_be, ia.bus_addr, ia.bus_wdata); end
            tick();
        end
        ia.bus_gnt = 1;
        tick();
        ia.bus_gnt = 0; ia.bus_rvalid = 1; ia.bus_rdata = 32'h1234_5678;
        total++; if (ia.ls_done !== 1'b0) begin bad++; $display("FAIL store_early got=%b exp=0", ia.ls_done); end
        tick();
        ia.bus_rvalid = 0;
        total++; if (ia.ls_done !== 1'b1) begin bad++; $display("FAIL store_done got=%b exp=1", ia.ls_done); end
        total++; if (ia.ls_rdata !== exp_ls_rdata || ia.if_rdata !== exp_if_rdata) begin
            bad++; $display("FAIL store_rdata got=%h/%h exp=%h/%h", ia.ls_rdata, ia.if_rdata, exp_ls_rdata, exp_if_rdata); end
        ia.ls_req = 0; ia.ls_we = 0;
        tick();
        total++; if (ia.ls_done !== 1'b0) begin bad++; $display("FAIL store_pulse got=%b exp=0", ia.ls_done); end
    endtask

    task automatic test_spurious();
        ia.bus_rvalid = 1; ia.bus_gnt = 1; ia.bus_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if ({ia.if_done, ia.ls_done, ia.bus_req} !== 3'b000 || ia.dbg_state !== IDLE) begin
                bad++; $display("FAIL spur_ctrl%0d got=%b/%0d exp=000/%0d", k, {ia.if_done, ia.ls_done, ia.bus_req}, ia.dbg_state, IDLE); end
            total++; if (ia.if_rdata !== exp_if_rdata || ia.ls_rdata !== exp_ls_rdata) begin
                bad++; $display("FAIL spur_rdata%0d got=%h/%h exp=%h/%h", k, ia.if_rdata, ia.ls_rdata, exp_if_rdata, exp_ls_rdata); end
        end
        ia.bus_rvalid = 0; ia.bus_gnt = 0; ia.bus_rdata = '0;
    endtask

    task automatic test_timeout();
        ia.if_req = 1; ia.if_addr = 32'h0000_0500;
        tick();
        for (int k = 0; k < 8; k++) begin
            total++; if (ia.bus_req !== 1'b1 || ia.err !== 1'b0 || ia.if_done !== 1'b0) begin
                bad++; $display("FAIL to_busy%0d got=%b/%b/%b exp=1/0/0", k, ia.bus_req, ia.err, ia.if_done); end
            tick();
        end
        exp_if_rdata = '0;
        total++; if (ia.bus_req !== 1'b0 || ia.if_done !== 1'b1) begin bad++; $display("FAIL to_done got=%b/%b exp=0/1", ia.bus_req, ia.if_done); end
        total++; if (ia.if_rdata !== exp_if_rdata || ia.err !== 1'b1) begin bad++; $display("FAIL to_err got=%h/%b exp=%h/1", ia.if_rdata, ia.err, exp_if_rdata); end
        ia.if_req = 0; ia.err_clr = 1;
        tick();
        ia.err_clr = 0;
        total++; if (ia.err !== 1'b0 || ia.dbg_state !== IDLE) begin bad++; $display("FAIL to_clr got=%b/%0d exp=0/%0d", ia.err, ia.dbg_state, IDLE); end

        ia.ls_req = 1; ia.ls_we = 0; ia.ls_be = 4'hF; ia.ls_addr = 32'h0000_0600;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) ia.err_clr = 1;
            tick();
        end
        ia.err_clr = 0;
        exp_ls_rdata = '0;
        total++; if (ia.err !== 1'b1) begin bad++; $display("FAIL to_set_wins got=%b exp=1", ia.err); end
        total++; if (ia.ls_done !== 1'b1 || ia.ls_rdata !== exp_ls_rdata) begin bad++; $display("FAIL to_ls got=%b/%h exp=1/%h", ia.ls_done, ia.ls_rdata, exp_ls_rdata); end
        ia.ls_req = 0;
        tick();
        total++; if (ia.err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", ia.err); end
        ia.err_clr = 1;
        tick();
        ia.err_clr = 0;
        total++; if (ia.err !== 1'b0) begin bad++; $display("FAIL to_clr2 got=%b exp=0", ia.err); end
    endtask

    task automatic test_reset_mid();
        ia.if_req = 1; ia.if_addr = 32'h0000_0700;
        tick();
        a_serve(32'h1234_5678);
        exp_if_rdata = 32'h1234_5678;
        total++; if (ia.if_rdata !== exp_if_rdata) begin bad++; $display("FAIL rmid_pre got=%h exp=%h", ia.if_rdata, exp_if_rdata); end
        ia.if_req = 0;
        tick();
        ia.if_req = 1; ia.if_addr = 32'h0000_0704;
        tick();
        ia.bus_gnt = 1;
        tick();
        ia.bus_gnt = 0;
        total++; if (ia.dbg_state !== WAIT) begin bad++; $display("FAIL rmid_wait got=%0d exp=%0d", ia.dbg_state, WAIT); end
        rst = 0;
        tick();
        rst = 1; ia.if_req = 0; ia.bus_rvalid = 1; ia.bus_rdata = 32'h0000_CAFE;
        exp_if_rdata = '0; exp_ls_rdata = '0;
        total++; if (ia.dbg_state !== IDLE || {ia.bus_req, ia.bus_we, ia.bus_be, ia.bus_addr, ia.bus_wdata} !== 70'h0) begin
            bad++; $display("FAIL rmid_bus got=%0d/%b/%h exp=%0d/0/0", ia.dbg_state, ia.bus_req, ia.bus_addr, IDLE); end
        total++; if (ia.if_rdata !== exp_if_rdata || ia.ls_rdata !== exp_ls_rdata || ia.err !== 1'b0) begin
            bad++; $display("FAIL rmid_regs got=%h/%h/%b exp=0/0/0", ia.if_rdata, ia.ls_rdata, ia.err); end
        for (int k = 0; k < 2; k++) begin
            tick();
            ia.bus_rvalid = 0;
            total++; if (ia.if_done !== 1'b0 || ia.ls_done !== 1'b0 || ia.dbg_state !== IDLE || ia.if_rdata !== exp_if_rdata) begin
                bad++; $display("FAIL rmid_late%0d got=%b/%b/%0d/%h exp=0/0/%0d/%h", k, ia.if_done, ia.ls_done, ia.dbg_state, ia.if_rdata, IDLE, exp_if_rdata); end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        for (int p = 0; p < 4; p++) begin
            ib.if_req = 1; ib.if_addr = 32'h0000_1002 + 32'(p * 16);
            ib.ls_req = 1; ib.ls_we = 0; ib.ls_be = 4'hF; ib.ls_addr = 32'h0000_2000 + 32'(p * 16);
            exp_q.push_back(32'h0000_2000 + 32'(p * 16));
            exp_q.push_back(32'h0000_1000 + 32'(p * 16));
            tick();
            exp_addr = exp_q.pop_front();
            total++; if (ib.bus_addr !== exp_addr) begin bad++; $display("FAIL rr_ls%0d got=%h exp=%h", p, ib.bus_addr, exp_addr); end
            b_serve(32'h5500_0000 + 32'(p));
            total++; if (ib.ls_done !== 1'b1 || ib.ls_rdata !== 32'h5500_0000 + 32'(p)) begin
                bad++; $display("FAIL rr_ls_done%0d got=%b/%h exp=1/%h", p, ib.ls_done, ib.ls_rdata, 32'h5500_0000 + 32'(p)); end
            ib.ls_req = 0;
            tick();
            tick();
            exp_addr = exp_q.pop_front();
            total++; if (ib.bus_addr !== exp_addr) begin bad++; $display("FAIL rr_if%0d got=%h exp=%h", p, ib.bus_addr, exp_addr); end
            b_serve(32'h6600_0000 + 32'(p));
            total++; if (ib.if_done !== 1'b1 || ib.if_rdata !== 32'h6600_0000 + 32'(p)) begin
                bad++; $display("FAIL rr_if_done%0d got=%b/%h exp=1/%h", p, ib.if_done, ib.if_rdata, 32'h6600_0000 + 32'(p)); end
            ib.if_req = 0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_store_stall();
        test_spurious();
        test_timeout();
        test_reset_mid();
        test_round_robin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Stall-capable memory arbiter for the next-generation multicycle RISC-V core.
- Merges the instruction-fetch channel and the load/store channel onto one shared single-port bus with a req/gnt/rvalid handshake.
- Holds the core via `stall` until each access completes.
- Adds variable-latency memory support, byte enables, selectable arbitration policy and a bus timeout. The current zero-wait-state interfaces have none of these.

Parameters:
- DPWIDTH, 32: data/address width; must be a multiple of 8.
- BEWIDTH, DPWIDTH/8: byte-enable width (derived; do not override).
- TIMEOUT, 255: maximum cycles in REQ+WAIT before abort; must be ≥ 2.
- TOWIDTH, $clog2(TIMEOUT+1): timeout counter width (derived).
- PRIORITY, 1: 0 = fetch wins, 1 = data wins, 2 = round-robin.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  DPWIDTH  fetch address.
- if_rdata  out  DPWIDTH  fetched word; held until the next fetch completes.
- if_done  out  1  one-cycle fetch completion pulse.
- ls_req  in  1  load/store request; level, held until ls_done.
- ls_we  in  1  1 = store.
- ls_be  in  BEWIDTH  store byte enables.
- ls_addr  in  DPWIDTH  data address.
- ls_wdata  in  DPWIDTH  store data.
- ls_rdata  out  DPWIDTH  load data; held until the next ls completion.
- ls_done  out  1  one-cycle load/store completion pulse.
- stall  out  1  (if_req & ~if_done) | (ls_req & ~ls_done); combinational.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_be  out  BEWIDTH  bus byte enables.
- bus_addr  out  DPWIDTH  word-aligned address; low $clog2(BEWIDTH) bits forced to 0.
- bus_wdata  out  DPWIDTH  bus write data.
- bus_gnt  in  1  bus accepts the request.
- bus_rvalid  in  1  response valid; also acts as write acknowledge.
- bus_rdata  in  DPWIDTH  bus read data.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (rst=0 at an edge):
  - State → IDLE; timeout counter = 0; round-robin pointer = fetch.
  - All bus_* outputs, if_rdata, ls_rdata, if_done, ls_done and err = 0.
  - Reset mid-transaction abandons the access; any bus_rvalid that arrives later is ignored.
- IDLE:
  - If any request is pending, the winner is selected and its we/be/addr/wdata are latched.
  - Fetch channel: we=0, be=all ones.
  - Next state is REQ.
- Arbitration when both requests are pending:
  - PRIORITY=0: fetch wins.
  - PRIORITY=1: data wins.
  - PRIORITY=2: the channel not served last wins; the pointer updates on each grant.
- REQ:
  - bus_req=1 with the latched fields; fields stay stable while bus_gnt=0.
  - bus_gnt=1 → WAIT.
  - bus_rvalid in REQ is ignored.
- WAIT:
  - bus_req=0.
  - bus_rvalid=1 → capture bus_rdata (for stores, capture is discarded) → DONE.
- DONE:
  - Assert the served channel's done for exactly 1 cycle.
  - Update that channel's rdata register on a read.
  - Next state is IDLE.
- Latency: from request sampled in IDLE (edge 0), the minimum is:
  - bus_req high during cycle 1;
  - gnt in cycle 1 and rvalid in cycle 2;
  - done high in cycle 3.
- Back-to-back: a request that becomes or stays pending during a transaction is evaluated on the next IDLE cycle. Minimum 4 cycles per access.
- Timeout:
  - The counter increments every cycle in REQ or WAIT and resets to 0 on entering IDLE.
  - On reaching TIMEOUT, the block moves to DONE with captured data = 0, err is set, and done still pulses so the core never hangs.
  - bus_req drops on the next edge.
- err:
  - Sticky; cleared by err_clr=1.
  - Set has priority over clear in the same cycle.
- Unsolicited bus_rvalid in IDLE or DONE is ignored. bus_gnt outside REQ is ignored.
- The done outputs never assert while in IDLE, REQ or WAIT.

Decomposition:
- Package rv_mem_pkg holds:
  - state_t enum {IDLE, REQ, WAIT, DONE};
  - chan_t enum {CH_IF, CH_LS};
  - priority constants PRIO_IF=0, PRIO_LS=1, PRIO_RR=2.
- Sub-module rv_mem_timeout (parametrised by TIMEOUT): counter with clear/enable inputs and an expired output.

Test Plan:
1. Single fetch, if_addr=0x0000_1006, gnt immediate, rvalid 1 cycle later with rdata=0x0041_0113 → bus_addr=0x0000_1004, bus_be=4'hF; if_done in cycle 3; if_rdata=0x0041_0113; stall low after done.
2. Store ls_addr=0x200, ls_be=4'b0011, wdata=0xDEAD_BEEF; gnt held low for 5 cycles → bus fields stable across all 5 cycles; ls_done 1 cycle after rvalid; ls_rdata unchanged.
3. Simultaneous if_req and ls_req:
   - PRIORITY=1 → LS served first, then IF.
   - PRIORITY=2 over 4 repeated pairs → grants alternate LS, IF, LS, IF.
4. TIMEOUT=8, bus never grants → bus_req high for 8 cycles, then done pulses with rdata=0 and err=1. err_clr=1 the next cycle → err=0. err_clr asserted on the same cycle as the set → err=1.
5. rst=0 asserted in WAIT, then bus_rvalid arrives → all outputs 0, state IDLE, no done pulse, rdata registers 0.
6. Spurious bus_rvalid in IDLE with rdata=0xFFFF_FFFF → no done pulse, if_rdata and ls_rdata unchanged.
